// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Synchronises board reset release, holds for HOLD_CYCLES, then
//            releases NUM_OUTS reset domains in order, GAP_CYCLES apart.
//            Optional software replay enabled by RESET_SEQ_SWRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUTS    = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sw_rst_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                rst_done
);

  localparam int c_MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam int c_IDX_W   = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [c_CNT_W-1:0]  c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'((NUM_OUTS > 1) ? NUM_OUTS - 2 : 0);
  localparam logic [NUM_OUTS-1:0] c_OUT_ONE   = NUM_OUTS'(1);
  localparam logic                c_SINGLE    = (NUM_OUTS == 1);

  localparam logic [1:0] c_S_HOLD    = 2'd0;
  localparam logic [1:0] c_S_RELEASE = 2'd1;
  localparam logic [1:0] c_S_DONE    = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic [c_IDX_W-1:0]     r_idx;
  logic [c_IDX_W-1:0]     w_idx_nxt;
  logic [c_IDX_W-1:0]     w_idx_inc;
  logic [NUM_OUTS-1:0]    w_out_nxt;
  logic                   w_done_nxt;
  logic                   w_sync_ok;
  logic                   w_hold_hit;
  logic                   w_gap_hit;
  logic                   w_last_idx;
  logic                   w_sw_hit;

  assign w_sync_ok  = r_sync[SYNC_STAGES-1];
  assign w_hold_hit = w_sync_ok && (r_cnt == c_HOLD_LAST);
  assign w_gap_hit  = (r_cnt == c_GAP_LAST);
  assign w_last_idx = (r_idx == c_IDX_LAST);
  assign w_idx_inc  = r_idx + c_IDX_W'(1);

`ifdef RESET_SEQ_SWRST_EN
  assign w_sw_hit = (r_state == c_S_DONE) && sw_rst_req;
`else
  // Port kept for a uniform footprint; deliberately left unconnected.
  logic w_unused_sw;
  assign w_unused_sw = sw_rst_req;
  assign w_sw_hit    = 1'b0;
`endif

  // Deassertion-only synchroniser; assertion reaches every flop asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_S_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      rst_n_out <= '0;
      rst_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      rst_n_out <= w_out_nxt;
      rst_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_S_HOLD: begin
        if (w_hold_hit) begin
          w_cnt_nxt   = '0;
          w_state_nxt = c_SINGLE ? c_S_DONE : c_S_RELEASE;
        end else if (w_sync_ok) begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      c_S_RELEASE: begin
        if (w_gap_hit) begin
          w_cnt_nxt = '0;
          w_idx_nxt = w_idx_inc;
          if (w_last_idx) begin
            w_state_nxt = c_S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      c_S_DONE: begin
        if (w_sw_hit) begin
          w_state_nxt = c_S_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_S_HOLD;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs; released bits only ever accumulate.
  always_comb begin
    w_out_nxt  = rst_n_out;
    w_done_nxt = rst_done;
    case (r_state)
      c_S_HOLD: begin
        if (w_hold_hit) begin
          w_out_nxt  = c_OUT_ONE;
          w_done_nxt = c_SINGLE;
        end
      end
      c_S_RELEASE: begin
        if (w_gap_hit) begin
          w_out_nxt  = rst_n_out | (c_OUT_ONE << w_idx_inc);
          w_done_nxt = w_last_idx;
        end
      end
      c_S_DONE: begin
        if (w_sw_hit) begin
          w_out_nxt  = '0;
          w_done_nxt = 1'b0;
        end else begin
          w_out_nxt  = '1;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_out_nxt  = '0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Self-checking bench for reset_sequencer against an edge-count
//            model of the release schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;
  localparam int SYNC = 2;
  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rst_n_out;
  logic         rst_done;
  logic         reset_n_b = 1'b0;
  logic         sw_rst_req_b = 1'b0;
  logic [0:0]   rst_n_out_b;
  logic         rst_done_b;

  int total = 0;
  int bad   = 0;
  int m_e, m_base, m_delay;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .NUM_OUTS(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out), .rst_done(rst_done)
  );

  reset_sequencer #(
    .SYNC_STAGES(3), .NUM_OUTS(1), .HOLD_CYCLES(8), .GAP_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n_b), .sw_rst_req(sw_rst_req_b),
    .rst_n_out(rst_n_out_b), .rst_done(rst_done_b)
  );

  // Released-domain count at edge m_e: first release at base+delay, one more per GAP.
  function automatic int exp_cnt();
    int d;
    if (m_e < m_base + m_delay) return 0;
    d = (m_e - m_base - m_delay) / GAP + 1;
    return (d > N) ? N : d;
  endfunction

  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] v;
    int c;
    c = exp_cnt();
    for (int i = 0; i < N; i++) v[i] = (i < c);
    return v;
  endfunction

  function automatic logic exp_done();
    return exp_cnt() == N;
  endfunction

  task automatic model_restart();
    m_e = 0; m_base = 0; m_delay = SYNC + HOLD;
  endtask

  task automatic tick();
`ifdef RESET_SEQ_SWRST_EN
    if (sw_rst_req && exp_cnt() == N) begin
      m_base  = m_e + 1;
      m_delay = HOLD;
    end
`endif
    @(posedge clk);
    m_e++;
    #1;
  endtask

  task automatic apply_reset(int cycles);
    sw_rst_req = 1'b0;
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_restart();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (rst_n_out !== '0 || rst_done !== 1'b0) begin
      bad++; $display("FAIL reset_initial: out=%b done=%b want out=0000 done=0", rst_n_out, rst_done);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rst_n_out !== '0 || rst_done !== 1'b0) begin
        bad++; $display("FAIL reset_hold cyc %0d: out=%b done=%b want out=0000 done=0", i, rst_n_out, rst_done);
      end
    end
    #1;
    reset_n = 1'b1;
    model_restart();
  endtask

  task automatic test_power_on();
    repeat (24) begin
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL power_on edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(2);
    while (m_e < 16) begin
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL mid_pre edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (rst_n_out !== '0 || rst_done !== 1'b0) begin
      bad++; $display("FAIL mid_async: out=%b done=%b want out=0000 done=0", rst_n_out, rst_done);
    end
    #2 reset_n = 1'b1;
    model_restart();
    repeat (24) begin
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL mid_replay edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
  endtask

  task automatic test_glitch();
    #2 reset_n = 1'b0;
    #0.5;
    total++;
    if (rst_n_out !== '0 || rst_done !== 1'b0) begin
      bad++; $display("FAIL glitch_async: out=%b done=%b want out=0000 done=0", rst_n_out, rst_done);
    end
    #0.5 reset_n = 1'b1;
    model_restart();
    repeat (24) begin
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL glitch_replay edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
  endtask

  task automatic test_sw_reset();
    apply_reset(3);
    while (m_e < 52) begin
      sw_rst_req = (m_e == 29);
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL sw_reset edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_ignored_req();
    apply_reset(2);
    while (m_e < 24) begin
      sw_rst_req = (m_e == 11);
      tick();
      total++;
      if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
        bad++; $display("FAIL ignored_req edge %0d: out=%b done=%b want out=%b done=%b",
                        m_e, rst_n_out, rst_done, exp_out(), exp_done());
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 10; it++) begin
      apply_reset($urandom_range(1, 4));
      len = $urandom_range(20, 60);
      for (int j = 0; j < len; j++) begin
        sw_rst_req = ($urandom_range(0, 7) == 0);
        tick();
        total++;
        if (rst_n_out !== exp_out() || rst_done !== exp_done()) begin
          bad++; $display("FAIL random it %0d edge %0d: out=%b done=%b want out=%b done=%b",
                          it, m_e, rst_n_out, rst_done, exp_out(), exp_done());
        end
        if ($urandom_range(0, 15) == 0) begin
          #($urandom_range(1, 6));
          reset_n = 1'b0;
          #1;
          total++;
          if (rst_n_out !== '0 || rst_done !== 1'b0) begin
            bad++; $display("FAIL random_async it %0d: out=%b done=%b want out=0000 done=0",
                            it, rst_n_out, rst_done);
          end
          #1 reset_n = 1'b1;
          model_restart();
        end
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_single_out();
    logic want;
    int   e_b;
    sw_rst_req_b = 1'b1;
    @(posedge clk);
    #2 reset_n_b = 1'b1;
    e_b = 0;
    repeat (30) begin
      @(posedge clk);
      e_b++;
      #1;
`ifdef RESET_SEQ_SWRST_EN
      // Held request replays every time DONE is reached: up at 11, 20, 29...
      want = (e_b >= 11) && (((e_b - 11) % 9) == 0);
`else
      want = (e_b >= 11);
`endif
      total++;
      if (rst_n_out_b[0] !== want || rst_done_b !== want) begin
        bad++; $display("FAIL single_out edge %0d: out=%b done=%b want %b", e_b, rst_n_out_b, rst_done_b, want);
      end
    end
    sw_rst_req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_glitch();
    test_mid_reset();
    test_sw_reset();
    test_ignored_req();
    test_random();
    test_single_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
